// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - two-requester register-file write-port arbiter with pending-write scoreboard
module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_hazard,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_wd,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_wd,
    input  logic [4:0]  rR1,
    input  logic [4:0]  rR2,
    output logic        busy1,
    output logic        busy2,
    output logic        rf_we,
    output logic [4:0]  rf_wr,
    output logic [31:0] rf_wd
);

    logic [31:0]      sb_q, sb_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_wr_q, rf_wr_d;
    logic [31:0]      rf_wd_q, rf_wd_d;

    logic             wait_at_max;
    logic             alu_win;
    logic [31:0]      clr_mask;
    logic [31:0]      set_mask;

    assign wait_at_max = (wait_q == CNT_W'(MAX_WAIT));
    // ALU wins when it is alone, or when it has been starved long enough.
    assign alu_win     = alu_valid && (!mem_valid || wait_at_max);

    // Nothing is accepted while reset is asserted.
    assign alu_ready   = rst_n && alu_win;
    assign mem_ready   = rst_n && mem_valid && !alu_win;

    assign busy1       = sb_q[rR1];
    assign busy2       = sb_q[rR2];
    assign iss_hazard  = iss_valid && sb_q[iss_rd] && (iss_rd != 5'd0);

    assign rf_we       = rf_we_q;
    assign rf_wr       = rf_wr_q;
    assign rf_wd       = rf_wd_q;

    // Next-state: starvation counter, write-port register and scoreboard update.
    always_comb begin
        wait_d   = wait_q;
        rf_we_d  = 1'b0;
        rf_wr_d  = rf_wr_q;
        rf_wd_d  = rf_wd_q;
        clr_mask = 32'd0;
        set_mask = 32'd0;

        if (!alu_valid || alu_ready) begin
            wait_d = '0;
        end else if (!wait_at_max) begin
            wait_d = wait_q + 1'b1;
        end

        if (alu_ready) begin
            rf_we_d = (alu_rd != 5'd0);
            rf_wr_d = alu_rd;
            rf_wd_d = alu_wd;
        end else if (mem_ready) begin
            rf_we_d = (mem_rd != 5'd0);
            rf_wr_d = mem_rd;
            rf_wd_d = mem_wd;
        end

        // The write being committed this cycle retires its pending bit; a
        // fresh issue to the same register re-arms it (set wins).
        if (rf_we_q) begin
            clr_mask = 32'd1 << rf_wr_q;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            set_mask = 32'd1 << iss_rd;
        end
        sb_d = ((sb_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_q    <= 32'd0;
            wait_q  <= '0;
            rf_we_q <= 1'b0;
            rf_wr_q <= 5'd0;
            rf_wd_q <= 32'd0;
        end else begin
            sb_q    <= sb_d;
            wait_q  <= wait_d;
            rf_we_q <= rf_we_d;
            rf_wr_q <= rf_wr_d;
            rf_wd_q <= rf_wd_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_hazard;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_wd;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;

    int total = 0;
    int bad   = 0;

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_hazard(iss_hazard),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .rR1(rR1), .rR2(rR2), .busy1(busy1), .busy2(busy2),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set of registers, starvation streak, last write.
    bit          m_pend [32];
    int          m_streak;
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    bit          m_init = 0;

    // Compare on the falling edge, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        bit e_ar, e_mr;
        e_ar = 0;
        e_mr = 0;
        if (rst_n) begin
            if (alu_valid && !mem_valid)      e_ar = 1;
            else if (mem_valid && !alu_valid) e_mr = 1;
            else if (alu_valid && mem_valid) begin
                if (m_streak >= MAX_WAIT) e_ar = 1;
                else                      e_mr = 1;
            end
        end
        if (m_init) begin
            chk("m_alu_ready", alu_ready, e_ar);
            chk("m_mem_ready", mem_ready, e_mr);
            chk("m_busy1", busy1, (rR1 != 0) && m_pend[rR1]);
            chk("m_busy2", busy2, (rR2 != 0) && m_pend[rR2]);
            chk("m_iss_hazard", iss_hazard, iss_valid && (iss_rd != 0) && m_pend[iss_rd]);
            chk("m_rf_we", rf_we, m_we);
            chk("m_rf_wr", rf_wr, m_wr);
            chk("m_rf_wd", rf_wd, m_wd);
        end
        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_streak = 0;
            m_we = 0;
            m_wr = 0;
            m_wd = 0;
            m_init = 1;
        end else begin
            if (m_we) m_pend[m_wr] = 0;
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
            if (alu_valid && !e_ar) m_streak = (m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1;
            else                    m_streak = 0;
            if (e_ar) begin
                m_we = (alu_rd != 0); m_wr = alu_rd; m_wd = alu_wd;
            end else if (e_mr) begin
                m_we = (mem_rd != 0); m_wr = mem_rd; m_wd = mem_wd;
            end else begin
                m_we = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        mem_valid = 0; mem_rd = 0; mem_wd = 0;
    endtask

    initial begin
        idle();
        rR1 = 5; rR2 = 0;
        // T1: reset with every requester asserting
        rst_n = 0; alu_valid = 1; alu_rd = 2; mem_valid = 1; mem_rd = 3; iss_valid = 1; iss_rd = 5;
        #1;
        chk("t1_alu_ready", alu_ready, 0);
        chk("t1_mem_ready", mem_ready, 0);
        tick();
        tick();
        chk("t1_rf_we", rf_we, 0);
        chk("t1_busy1", busy1, 0);
        chk("t1_busy2", busy2, 0);
        chk("t1_rf_wr", rf_wr, 0);

        // T2: single ALU writeback
        rst_n = 1; idle(); iss_valid = 1; iss_rd = 5; #1;
        chk("t2_no_hazard", iss_hazard, 0);
        tick();
        idle(); alu_valid = 1; alu_rd = 5; alu_wd = 32'h1234; #1;
        chk("t2_alu_ready", alu_ready, 1);
        chk("t2_busy_pending", busy1, 1);
        tick();
        idle(); #1;
        chk("t2_rf_we", rf_we, 1);
        chk("t2_rf_wr", rf_wr, 5);
        chk("t2_rf_wd", rf_wd, 32'h1234);
        chk("t2_busy_commit", busy1, 1);
        tick();
        chk("t2_rf_we_off", rf_we, 0);
        chk("t2_busy_clear", busy1, 0);
        chk("t2_rf_wd_hold", rf_wd, 32'h1234);

        // T3: collision, mem first then alu
        alu_valid = 1; alu_rd = 3; alu_wd = 32'h33; mem_valid = 1; mem_rd = 4; mem_wd = 32'h44; #1;
        chk("t3_mem_first", mem_ready, 1);
        chk("t3_alu_wait", alu_ready, 0);
        tick();
        mem_valid = 0; #1;
        chk("t3_alu_second", alu_ready, 1);
        chk("t3_wr_first", rf_wr, 4);
        chk("t3_wd_first", rf_wd, 32'h44);
        tick();
        idle(); #1;
        chk("t3_wr_second", rf_wr, 3);
        chk("t3_wd_second", rf_wd, 32'h33);
        tick();

        // T4: starvation; ALU forced through on its fifth waiting cycle
        alu_valid = 1; alu_rd = 10; alu_wd = 32'hA;
        for (int k = 0; k < 5; k++) begin
            mem_valid = 1; mem_rd = 5'(11 + k); mem_wd = 32'h100 + k; #1;
            chk("t4_alu_ready", alu_ready, (k == 4));
            chk("t4_mem_ready", mem_ready, (k != 4));
            tick();
        end
        alu_valid = 0; #1;
        chk("t4_alu_wr", rf_wr, 10);
        chk("t4_alu_we", rf_we, 1);
        chk("t4_mem_after", mem_ready, 1);
        tick();
        idle(); #1;
        chk("t4_mem_wr", rf_wr, 15);
        tick();

        // T5: write to x0 is accepted but not committed
        alu_valid = 1; alu_rd = 0; alu_wd = 32'hDEAD; #1;
        chk("t5_x0_ready", alu_ready, 1);
        tick();
        idle(); #1;
        chk("t5_x0_no_we", rf_we, 0);
        // set/clear race on x7
        iss_valid = 1; iss_rd = 7; rR1 = 7;
        tick();
        idle(); alu_valid = 1; alu_rd = 7; alu_wd = 32'h77;
        tick();
        idle(); iss_valid = 1; iss_rd = 7; #1;
        chk("t5_we7", rf_we, 1);
        chk("t5_wr7", rf_wr, 7);
        tick();
        idle(); #1;
        chk("t5_busy7_kept", busy1, 1);
        tick();
        chk("t5_busy7_still", busy1, 1);

        // T6: second issue to a pending register flags a hazard
        rR1 = 0; rR2 = 9;
        iss_valid = 1; iss_rd = 9; #1;
        chk("t6_first_issue", iss_hazard, 0);
        tick();
        #1;
        chk("t6_second_issue", iss_hazard, 1);
        chk("t6_busy2", busy2, 1);
        chk("t6_x0_busy", busy1, 0);
        iss_rd = 0; #1;
        chk("t6_x0_no_hazard", iss_hazard, 0);
        tick();
        idle();

        // Mid-operation reset drops pending state
        alu_valid = 1; alu_rd = 12; alu_wd = 32'hC;
        tick();
        rst_n = 0; idle();
        tick();
        rst_n = 1; rR1 = 12; rR2 = 9; #1;
        chk("rst_busy_cleared", busy2, 0);
        chk("rst_we_cleared", rf_we, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
